// File: rtl/tt_checker_pkg.sv
// tt_checker_pkg: shared FSM state encoding and MISR constants for the truth-table checker
package tt_checker_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FIN} state_t;
  localparam int MISR_W = 8;
  localparam logic [MISR_W-1:0] MISR_TAP = 8'hB8;
endpackage

// File: rtl/truth_table_checker_misr.sv
// tt_misr: 8-bit MISR compacting one response bit per enabled cycle
module tt_misr import tt_checker_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              d,
  output logic [MISR_W-1:0] sig
);
  // shift in the tap parity XOR the new sample; clear wins over update
  always_ff @(posedge clk or posedge rst)
    if (rst) sig <= '0;
    else if (clr) sig <= '0;
    else if (en) sig <= {sig[MISR_W-2:0], ^(sig & MISR_TAP) ^ d};
endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: walks every input vector, compares resp to EXPECT; define TT_CHECKER_SIG_EN for the sig MISR output
module truth_table_checker import tt_checker_pkg::*; #(
  parameter int          N_IN   = 2,
  parameter logic [15:0] EXPECT = 16'h0006,
  parameter int          SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              resp,
  output logic [N_IN-1:0]   vec,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_cnt,
  output logic [N_IN-1:0]   first_fail
`ifdef TT_CHECKER_SIG_EN
  ,
  output logic [MISR_W-1:0] sig
`endif
);
  localparam logic [3:0] RLD = 4'(SETTLE - 1);
  state_t st;
  logic [3:0] cnt;
  logic mis;
  assign mis = resp != EXPECT[vec];
  assign pass = done && err_cnt == '0;
  // run sequencer: settle each vector, sample once, advance until the last vector
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      vec <= '0;
      err_cnt <= '0;
      first_fail <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
    end else case (st)
      IDLE, FIN: if (start) begin
        st <= DRIVE;
        vec <= '0;
        err_cnt <= '0;
        first_fail <= '0;
        busy <= 1'b1;
        done <= 1'b0;
        cnt <= RLD;
      end
      DRIVE: if (cnt == '0) st <= SAMPLE; else cnt <= cnt - 1'b1;
      SAMPLE: begin
        if (mis) begin
          err_cnt <= err_cnt + 1'b1;
          if (err_cnt == '0) first_fail <= vec;
        end
        if (&vec) begin
          st <= FIN;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          st <= DRIVE;
          vec <= vec + 1'b1;
          cnt <= RLD;
        end
      end
      default: st <= IDLE;
    endcase
`ifdef TT_CHECKER_SIG_EN
  logic clr;
  assign clr = start && (st == IDLE || st == FIN);
  tt_misr u_misr (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .en(st == SAMPLE),
    .d(resp),
    .sig(sig)
  );
`endif
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: XOR (N_IN=2,SETTLE=1) and majority (N_IN=3,SETTLE=2) instances against a table-driven model
module tb_truth_table_checker;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] starts;
  logic [15:0] tab [2];
  logic [1:0] vec0, ff0;
  logic [2:0] vec1, ff1, err0;
  logic [3:0] err1;
  logic busy0, done0, pass0, busy1, done1, pass1, r0, r1;
  logic [3:0] vx [2], ex [2], fx [2];
  logic bx [2], dx [2], px [2];
  int nin [2] = '{2, 3};
  int settle [2] = '{1, 2};
  logic [15:0] expv [2] = '{16'h0006, 16'h00E8};
  int tests = 0, fails = 0;
`ifdef TT_CHECKER_SIG_EN
  logic [7:0] sx [2];
`endif

  always #5 clk = ~clk;

  assign r0 = tab[0][vec0];
  assign r1 = tab[1][vec1];
  assign vx[0] = {2'b0, vec0};
  assign vx[1] = {1'b0, vec1};
  assign ex[0] = {1'b0, err0};
  assign ex[1] = err1;
  assign fx[0] = {2'b0, ff0};
  assign fx[1] = {1'b0, ff1};
  assign bx[0] = busy0;
  assign bx[1] = busy1;
  assign dx[0] = done0;
  assign dx[1] = done1;
  assign px[0] = pass0;
  assign px[1] = pass1;

  truth_table_checker dut0 (
    .clk(clk), .rst(rst), .start(starts[0]), .resp(r0), .vec(vec0), .busy(busy0),
    .done(done0), .pass(pass0), .err_cnt(err0), .first_fail(ff0)
`ifdef TT_CHECKER_SIG_EN
    , .sig(sx[0])
`endif
  );

  truth_table_checker #(.N_IN(3), .EXPECT(16'h00E8), .SETTLE(2)) dut1 (
    .clk(clk), .rst(rst), .start(starts[1]), .resp(r1), .vec(vec1), .busy(busy1),
    .done(done1), .pass(pass1), .err_cnt(err1), .first_fail(ff1)
`ifdef TT_CHECKER_SIG_EN
    , .sig(sx[1])
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] misr_model(input int n, input logic [15:0] t);
    logic [7:0] s = 8'h00;
    for (int v = 0; v < n; v++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3] ^ t[v]};
    return s;
  endfunction

  task automatic run(input int d, input logic [15:0] t, input int inj);
    int n, lat, k, e, f;
    n = 1 << nin[d];
    lat = n * (settle[d] + 1);
    e = 0;
    f = 0;
    for (int v = n - 1; v >= 0; v--) if (t[v] != expv[d][v]) begin e++; f = v; end
    tab[d] = t;
    @(negedge clk);
    starts[d] = 1'b1;
    @(negedge clk);
    starts[d] = 1'b0;
    chk("clr_err", ex[d], 0);
    chk("clr_done", dx[d], 0);
    k = 0;
    while (!dx[d] && k < lat + 20) begin
      chk("vec_walk", vx[d], k / (settle[d] + 1));
      chk("busy_run", bx[d], 1);
      starts[d] = (k == inj);
      @(negedge clk);
      k++;
    end
    starts[d] = 1'b0;
    chk("latency", k, lat);
    chk("err_cnt", ex[d], e);
    chk("first_fail", fx[d], f);
    chk("pass", px[d], e == 0);
    chk("busy_fin", bx[d], 0);
    chk("vec_fin", vx[d], n - 1);
`ifdef TT_CHECKER_SIG_EN
    chk("sig", sx[d], misr_model(n, t));
`endif
    repeat (2) @(negedge clk);
    chk("done_hold", dx[d], 1);
    chk("vec_hold", vx[d], n - 1);
  endtask

  task automatic mid_reset(input int d);
    tab[d] = ~expv[d];
    @(negedge clk);
    starts[d] = 1'b1;
    @(negedge clk);
    starts[d] = 1'b0;
    repeat (settle[d] + 1) @(negedge clk);
    chk("pre_rst_vec", vx[d], 1);
    chk("pre_rst_err", ex[d], 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_vec", vx[d], 0);
    chk("rst_err", ex[d], 0);
    chk("rst_ff", fx[d], 0);
    chk("rst_busy", bx[d], 0);
    chk("rst_done", dx[d], 0);
    chk("rst_pass", px[d], 0);
`ifdef TT_CHECKER_SIG_EN
    chk("rst_sig", sx[d], 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    run(d, expv[d], -1);
  endtask

  initial begin
    int d, m;
    logic [15:0] t;
    rst = 1'b1;
    starts = 2'b00;
    tab[0] = 16'h0;
    tab[1] = 16'h0;
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("init_vec", vx[i], 0);
      chk("init_err", ex[i], 0);
      chk("init_busy", bx[i], 0);
      chk("init_done", dx[i], 0);
      chk("init_pass", px[i], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    run(0, 16'h0006, -1);
    run(0, 16'h0000, -1);
    run(1, 16'h00E8, -1);
    run(1, 16'h00E8, 6);
    run(0, 16'h0006, 4);
    mid_reset(0);
    mid_reset(1);
    repeat (14) begin
      d = int'($urandom_range(0, 1));
      m = int'($urandom_range(0, 2));
      t = m == 0 ? expv[d] : m == 1 ? expv[d] ^ (16'h1 << $urandom_range(0, (1 << nin[d]) - 1)) : 16'($urandom);
      run(d, t, -1);
    end
`ifdef TT_CHECKER_SIG_EN
    for (int i = 0; i < 2; i++) begin
      t = expv[0] ^ (16'h1 << i);
      run(0, t, -1);
      chk("sig_differs", sx[0] != misr_model(4, expv[0]), 1);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
